// File: rtl/stage_mem_lsu_pkg.sv
// Shared types and funct3 decode for the MEM-stage load/store unit.
// No logic; imported by the LSU top and its data-alignment helper.
package stage_mem_lsu_pkg;

    localparam logic [2:0] MEM_ACCESS_B  = 3'b000;
    localparam logic [2:0] MEM_ACCESS_H  = 3'b001;
    localparam logic [2:0] MEM_ACCESS_W  = 3'b010;
    localparam logic [2:0] MEM_ACCESS_D  = 3'b011;
    localparam logic [2:0] MEM_ACCESS_BU = 3'b100;
    localparam logic [2:0] MEM_ACCESS_HU = 3'b101;
    localparam logic [2:0] MEM_ACCESS_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} lsu_state_t;

    // log2 of access size in bytes; doubleword collapses to word on a 32-bit bus
    function automatic logic [1:0] access_size(input logic [2:0] width, input logic wide);
        case (width)
            MEM_ACCESS_B, MEM_ACCESS_BU: access_size = 2'd0;
            MEM_ACCESS_H, MEM_ACCESS_HU: access_size = 2'd1;
            MEM_ACCESS_D:                access_size = wide ? 2'd3 : 2'd2;
            default:                     access_size = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_lsu_data_align.sv
// Byte-lane steering: width + address low bits -> byte enables, shifted store data,
// and extracted/extended load data. Purely combinational.
module stage_mem_lsu_data_align
    import stage_mem_lsu_pkg::*;
#(
    parameter int WD_SIZE = 32,
    parameter int NB      = WD_SIZE / 8,
    parameter int LB      = $clog2(WD_SIZE / 8)
) (
    input  logic [2:0]         width,
    input  logic [LB-1:0]      addr_lo,
    input  logic [WD_SIZE-1:0] st_data,
    input  logic [WD_SIZE-1:0] rd_data,
    output logic [NB-1:0]      be,
    output logic [WD_SIZE-1:0] wr_data,
    output logic [WD_SIZE-1:0] ld_data,
    output logic [LB-1:0]      lane,
    output logic               misaligned
);

    logic [1:0]         sz;
    logic [LB-1:0]      mask;
    logic [NB-1:0]      bmask;
    logic [WD_SIZE-1:0] shifted;
    logic               sbit;

    always_comb begin
        sz = access_size(width, NB == 8);
        case (sz)
            2'd0:    mask = '0;
            2'd1:    mask = LB'(1);
            2'd2:    mask = LB'(3);
            default: mask = LB'(7);
        endcase
        misaligned = (addr_lo & mask) != '0;
        lane       = addr_lo & ~mask;

        bmask = '0;
        for (int i = 0; i < NB; i++) begin
            bmask[i] = (i < (1 << sz));
        end
        be      = bmask << lane;
        wr_data = st_data << {lane, 3'b000};

        shifted = rd_data >> {lane, 3'b000};
        case (sz)
            2'd0:    sbit = shifted[7];
            2'd1:    sbit = shifted[15];
            2'd2:    sbit = shifted[31];
            default: sbit = shifted[WD_SIZE-1];
        endcase
        for (int i = 0; i < WD_SIZE; i++) begin
            ld_data[i] = (i < (8 << sz)) ? shifted[i] : (sbit & ~width[2]);
        end
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// MEM stage with req/gnt/rvalid data port, sub-word access, bus timeout and registered WB outputs.
// Optional MEM_MISALIGN_EXC_EN: misaligned H/W/D raises exc_misalign_o instead of truncating the address.
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int WD_SIZE        = 32,
    parameter int REG_ADDR_SIZE  = 5,
    parameter int PC_SIZE        = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_i,
    input  logic [WD_SIZE-1:0]       alu_result_i,
    input  logic [WD_SIZE-1:0]       rs2_data_i,
    input  logic [REG_ADDR_SIZE-1:0] rd_i,
    input  logic [PC_SIZE-1:0]       pc_br_i,
    input  logic                     ctrl_ld_i,
    input  logic                     ctrl_st_i,
    input  logic                     ctrl_br_i,
    input  logic                     alu_cmp_i,
    input  logic [2:0]               ctrl_mem_width_i,
    input  logic                     ctrl_reg_write_i,
    input  logic                     stall_proc_i,
    output logic                     stall_mem_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [WD_SIZE-1:0]       dmem_addr_o,
    output logic [WD_SIZE/8-1:0]     dmem_be_o,
    output logic [WD_SIZE-1:0]       dmem_wr_data_o,
    input  logic                     dmem_gnt_i,
    input  logic                     dmem_rvalid_i,
    input  logic [WD_SIZE-1:0]       dmem_rd_data_i,
    output logic                     valid_o,
    output logic [REG_ADDR_SIZE-1:0] rd_o,
    output logic                     ctrl_reg_write_o,
    output logic [WD_SIZE-1:0]       wb_data_o,
    output logic                     take_br_o,
    output logic [PC_SIZE-1:0]       pc_br_o,
    output logic                     bus_err_o,
    output logic                     exc_misalign_o,
    output logic [WD_SIZE-1:0]       bypass_mem_data_o,
    output logic                     bypass_ctrl_reg_write_mem_o
);

    localparam int NB = WD_SIZE / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t state, state_next;
    logic [CW-1:0]            cnt;
    logic [WD_SIZE-LB-1:0]    q_addr_hi;
    logic [NB-1:0]            q_be;
    logic [WD_SIZE-1:0]       q_wdata;
    logic [REG_ADDR_SIZE-1:0] q_rd;
    logic [2:0]               q_width;
    logic [LB-1:0]            q_lane;
    logic                     q_we, q_reg_write, q_exc;

    logic [2:0]         al_width;
    logic [LB-1:0]      al_lo, al_lane;
    logic [NB-1:0]      al_be;
    logic [WD_SIZE-1:0] al_wdata, al_ld;
    logic               misaligned;
    logic               mem_op, mis_exc, start, done_ok, timeout, retire;

    // Before a request is captured the aligner sees EX inputs; afterwards the held access
    assign al_width = (state == IDLE) ? ctrl_mem_width_i : q_width;
    assign al_lo    = (state == IDLE) ? alu_result_i[LB-1:0] : q_lane;

    stage_mem_lsu_data_align #(.WD_SIZE(WD_SIZE)) u_align (
        .width      (al_width),
        .addr_lo    (al_lo),
        .st_data    (rs2_data_i),
        .rd_data    (dmem_rd_data_i),
        .be         (al_be),
        .wr_data    (al_wdata),
        .ld_data    (al_ld),
        .lane       (al_lane),
        .misaligned (misaligned)
    );

    assign mem_op = (state == IDLE) & valid_i & (ctrl_ld_i | ctrl_st_i) & ~stall_proc_i;
`ifdef MEM_MISALIGN_EXC_EN
    assign mis_exc = mem_op & misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign mis_exc = 1'b0;
`endif
    assign start   = mem_op & ~mis_exc;
    // rvalid is accepted in the grant cycle as well as in WAIT_R
    assign done_ok = ((state == REQ) & dmem_gnt_i & (q_we | dmem_rvalid_i)) |
                     ((state == WAIT_R) & dmem_rvalid_i);
    assign timeout = (TIMEOUT_CYCLES != 0) & (state != IDLE) & ~done_ok &
                     (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign retire  = done_ok | timeout;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (retire) state_next = IDLE;
                     else if (dmem_gnt_i) state_next = WAIT_R;
            WAIT_R:  if (retire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o  = (state == REQ);
        dmem_we_o   = (state == REQ) & q_we;
        stall_mem_o = start | ((state != IDLE) & ~retire);
    end

    always_ff @(posedge clk) begin
        if (reset || state == IDLE || retire) cnt <= '0;
        else                                  cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_addr_hi <= '0; q_be <= '0; q_wdata <= '0; q_rd <= '0;
            q_width <= '0; q_lane <= '0; q_we <= 1'b0; q_reg_write <= 1'b0;
        end else if (start) begin
            q_addr_hi   <= alu_result_i[WD_SIZE-1:LB];
            q_be        <= al_be;
            q_wdata     <= al_wdata;
            q_rd        <= rd_i;
            q_width     <= ctrl_mem_width_i;
            q_lane      <= al_lane;
            q_we        <= ctrl_st_i;
            q_reg_write <= ctrl_reg_write_i;
        end
    end

    assign dmem_addr_o    = {q_addr_hi, {LB{1'b0}}};
    assign dmem_be_o      = q_be;
    assign dmem_wr_data_o = q_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o <= 1'b0; rd_o <= '0; ctrl_reg_write_o <= 1'b0; wb_data_o <= '0;
            take_br_o <= 1'b0; pc_br_o <= '0; bus_err_o <= 1'b0; q_exc <= 1'b0;
        end else if (retire) begin
            valid_o          <= 1'b1;
            rd_o             <= q_rd;
            ctrl_reg_write_o <= q_reg_write & ~q_we & ~timeout;
            wb_data_o        <= (q_we | timeout) ? '0 : al_ld;
            take_br_o        <= 1'b0;
            bus_err_o        <= timeout;
            q_exc            <= 1'b0;
        end else if (mis_exc) begin
            valid_o          <= 1'b1;
            rd_o             <= '0;
            ctrl_reg_write_o <= 1'b0;
            wb_data_o        <= alu_result_i;
            take_br_o        <= 1'b0;
            bus_err_o        <= 1'b0;
            q_exc            <= 1'b1;
        end else if (state == IDLE && !stall_proc_i && !start) begin
            valid_o          <= valid_i;
            rd_o             <= ctrl_reg_write_i ? rd_i : '0;
            ctrl_reg_write_o <= valid_i & ctrl_reg_write_i;
            wb_data_o        <= alu_result_i;
            take_br_o        <= valid_i & ctrl_br_i & alu_cmp_i;
            pc_br_o          <= pc_br_i;
            bus_err_o        <= 1'b0;
            q_exc            <= 1'b0;
        end else begin
            valid_o          <= 1'b0;
            ctrl_reg_write_o <= 1'b0;
            take_br_o        <= 1'b0;
            bus_err_o        <= 1'b0;
            q_exc            <= 1'b0;
        end
    end

    assign exc_misalign_o              = q_exc;
    assign bypass_mem_data_o           = alu_result_i;
    assign bypass_ctrl_reg_write_mem_o = valid_i & ctrl_reg_write_i & ~ctrl_ld_i;

endmodule
